serial_frame_tx: RTL

//  Transmit side of the single-wire port-routing protocol. Accepts one frame request
//  (port, length, payload) over a valid/ready handshake and serialises it onto ser_out.

---
 rtl/serial_frame_tx_pkg.sv | 20 ++
 rtl/serial_frame_tx_piso.sv | 30 +++
 rtl/serial_frame_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the single-wire port-routing protocol. The transmitter
// and the receiving demux both import this, so they agree on field widths,
// line levels and phase encoding.
package serial_frame_tx_pkg;

  localparam int DEF_PORT_W = 2;
  localparam int DEF_LEN_W  = 5;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PORT = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_STOP = 3'd4
  } tx_state_t;

endpackage

// File: rtl/serial_frame_tx_piso.sv
// Loadable parallel-in/serial-out shift register. The same block serves the
// MSB-first header and the LSB-first payload; msb_first selects which end is
// presented on bit_out and the matching shift direction.
module frame_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clk_en,
  input  logic         load,
  input  logic         shift,
  input  logic         msb_first,
  input  logic [W-1:0] din,
  output logic         bit_out
);

  logic [W-1:0] q;

  assign bit_out = msb_first ? q[W-1] : q[0];

  // Load a new word or step it one position toward the output end.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (load)
        q <= din;
      else if (shift)
        q <= msb_first ? (q << 1) : (q >> 1);
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Transmit side of the single-wire port-routing protocol. A frame request is
// accepted in IDLE (the start bit goes out on the accept edge), then the port
// and length fields are sent MSB-first, the payload LSB-first, and a stop bit
// that also serves as the minimum inter-frame gap.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int PORT_W = DEF_PORT_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DATA_W = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [PORT_W-1:0] tx_port,
  input  logic [LEN_W-1:0]  tx_len,
  input  logic [DATA_W-1:0] tx_data,
  output logic              ser_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int HDR_W = PORT_W + LEN_W;

  tx_state_t        state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] len_q;
  logic             ser_nxt;
  logic             done_nxt;
  logic             accept;
  logic             hdr_shift;
  logic             pay_shift;
  logic             hdr_bit;
  logic             pay_bit;

  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = (state != ST_IDLE);
  assign accept   = clk_en & tx_valid & tx_ready;

  // Header register: {port, len} shifted out MSB-first.
  frame_piso #(.W(HDR_W)) u_hdr (
    .clk       (clk),
    .clk_en    (clk_en),
    .load      (accept),
    .shift     (hdr_shift),
    .msb_first (1'b1),
    .din       ({tx_port, tx_len}),
    .bit_out   (hdr_bit)
  );

  // Payload register: data shifted out LSB-first.
  frame_piso #(.W(DATA_W)) u_pay (
    .clk       (clk),
    .clk_en    (clk_en),
    .load      (accept),
    .shift     (pay_shift),
    .msb_first (1'b0),
    .din       (tx_data),
    .bit_out   (pay_bit)
  );

  // Length copy used to choose DATA or STOP at the end of the header and to
  // seed the payload bit counter; it is only read after an accept.
  always_ff @(posedge clk) begin
    if (accept)
      len_q <= tx_len;
  end

  // Phase sequencing, bit counting and next line level; nothing moves without clk_en.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ser_nxt   = ser_out;
    done_nxt  = 1'b0;
    hdr_shift = 1'b0;
    pay_shift = 1'b0;
    if (clk_en) begin
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            ser_nxt   = START_BIT;
            state_nxt = ST_PORT;
            cnt_nxt   = LEN_W'(PORT_W - 1);
          end
        end
        ST_PORT: begin
          ser_nxt   = hdr_bit;
          hdr_shift = 1'b1;
          if (cnt == '0) begin
            state_nxt = ST_LEN;
            cnt_nxt   = LEN_W'(LEN_W - 1);
          end else begin
            cnt_nxt = cnt - LEN_W'(1);
          end
        end
        ST_LEN: begin
          ser_nxt   = hdr_bit;
          hdr_shift = 1'b1;
          if (cnt == '0) begin
            if (len_q == '0) begin
              state_nxt = ST_STOP;
            end else begin
              state_nxt = ST_DATA;
              cnt_nxt   = len_q - LEN_W'(1);
            end
          end else begin
            cnt_nxt = cnt - LEN_W'(1);
          end
        end
        ST_DATA: begin
          ser_nxt   = pay_bit;
          pay_shift = 1'b1;
          if (cnt == '0)
            state_nxt = ST_STOP;
          else
            cnt_nxt = cnt - LEN_W'(1);
        end
        ST_STOP: begin
          ser_nxt   = LINE_IDLE;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: begin
          ser_nxt   = LINE_IDLE;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Control state and the registered line; reset drops the line high at once.
  // tx_done is rewritten every clock so it is a single-clock pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ser_out <= LINE_IDLE;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ser_out <= ser_nxt;
      tx_done <= done_nxt;
    end
  end

endmodule
